// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-level round-robin arbiter that shares one FIFO
// write port among NREQ requesters. A grant is held until the grantee's last
// beat is written or MAXBEATS beats have been written. Writes are gated by the
// FIFO full flag.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DSIZE    = 8,
  parameter int unsigned MAXBEATS = 16
) (
  input  logic                    i_wr_clk,
  input  logic                    i_wr_rst,
  input  logic [NREQ-1:0]         i_valid,
  input  logic [NREQ*DSIZE-1:0]   i_data,
  input  logic [NREQ-1:0]         i_last,
  output logic [NREQ-1:0]         o_ready,
  input  logic                    i_fifo_full,
  output logic                    o_fifo_wr_en,
  output logic [DSIZE-1:0]        o_fifo_wr_data,
  output logic [NREQ-1:0]         o_grant,
  output logic                    o_busy,
  output logic                    o_trunc
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(MAXBEATS);
  localparam logic [NREQ-1:0] GRANT_ONE = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]   LAST_IDX  = PW'(NREQ - 1);
  localparam logic [CW-1:0]   CAP_CNT   = CW'(MAXBEATS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e            state_q;
  logic [PW-1:0]     gidx_q;
  logic [PW-1:0]     rr_ptr_q;
  logic [CW-1:0]     beat_cnt_q;
  logic [NREQ-1:0]   grant_q;
  logic              busy_q;
  logic              trunc_q;

  logic [DSIZE-1:0]  data_arr [NREQ];
  logic [PW-1:0]     win_idx;
  logic              win_found;
  logic              wr_en;
  logic              at_cap;
  logic [PW-1:0]     rr_next;

  // Unpack the flat data bus into one lane per requester
  for (genvar r = 0; r < NREQ; r++) begin : g_lane
    assign data_arr[r] = i_data[r*DSIZE +: DSIZE];
  end

  // Round-robin winner: first valid requester at or after rr_ptr, mod NREQ
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(rr_ptr_q) + i) % NREQ;
      if (!win_found && i_valid[PW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  // Write-side handshake, driven only while a grant is held
  always_comb begin
    o_ready        = '0;
    wr_en          = 1'b0;
    o_fifo_wr_data = data_arr[gidx_q];
    if (state_q == ST_BUSY) begin
      o_ready[gidx_q] = ~i_fifo_full;
      wr_en           = i_valid[gidx_q] & ~i_fifo_full;
    end
  end

  assign o_fifo_wr_en = wr_en;
  assign at_cap       = (beat_cnt_q == CAP_CNT);
  assign rr_next      = (gidx_q == LAST_IDX) ? '0 : gidx_q + PW'(1);

  // Arbitration FSM with registered grant, busy and truncation pulse
  always_ff @(posedge i_wr_clk or negedge i_wr_rst) begin
    if (!i_wr_rst) begin
      state_q    <= ST_IDLE;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            state_q    <= ST_BUSY;
            gidx_q     <= win_idx;
            grant_q    <= GRANT_ONE << win_idx;
            busy_q     <= 1'b1;
            beat_cnt_q <= '0;
          end
        end
        ST_BUSY: begin
          if (wr_en) begin
            beat_cnt_q <= beat_cnt_q + CW'(1);
            if (i_last[gidx_q] || at_cap) begin
              state_q  <= ST_IDLE;
              grant_q  <= '0;
              busy_q   <= 1'b0;
              rr_ptr_q <= rr_next;
              trunc_q  <= at_cap & ~i_last[gidx_q];
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = busy_q;
  assign o_trunc = trunc_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus randomized traffic,
// checked each cycle against a packet-level behavioural model.
module tb_fifo_wr_arbiter;

  localparam int NREQ     = 4;
  localparam int DSIZE    = 8;
  localparam int MAXBEATS = 16;
  localparam int QD       = 256;

  logic                  clk = 1'b0;
  logic                  wr_rst;
  logic [NREQ-1:0]       valid;
  logic [NREQ*DSIZE-1:0] data;
  logic [NREQ-1:0]       last;
  logic [NREQ-1:0]       ready;
  logic                  fifo_full;
  logic                  wr_en;
  logic [DSIZE-1:0]      wr_data;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  trunc;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBEATS(MAXBEATS)) dut (
    .i_wr_clk       (clk),
    .i_wr_rst       (wr_rst),
    .i_valid        (valid),
    .i_data         (data),
    .i_last         (last),
    .o_ready        (ready),
    .i_fifo_full    (fifo_full),
    .o_fifo_wr_en   (wr_en),
    .o_fifo_wr_data (wr_data),
    .o_grant        (grant),
    .o_busy         (busy),
    .o_trunc        (trunc)
  );

  // Per-requester beat streams: {last, data}
  logic [DSIZE:0] qmem [NREQ][QD];
  int qhd [NREQ];
  int qtl [NREQ];

  int n_checks = 0;
  int n_fail   = 0;

  // Packet-level model: who owns the port, beats written in this grant,
  // where round-robin resumes, and whether the last release was a cut
  int   owner;
  int   rr;
  int   cnt;
  logic exp_trunc;
  logic exp_wr;

  // Stimulus knobs
  int full_at, full_left, stall_req, stall_at, stall_left, full_pct, stall_pct;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qcount(input int r);
    return qtl[r] - qhd[r];
  endfunction

  task automatic push_beat(input int r, input logic [DSIZE-1:0] d, input logic l);
    qmem[r][qtl[r] % QD] = {l, d};
    qtl[r]++;
  endtask

  task automatic push_pkt(input int r, input int len, input int base);
    for (int i = 0; i < len; i++) push_beat(r, DSIZE'(base + i), (i == len - 1));
  endtask

  task automatic model_reset();
    owner     = -1;
    rr        = 0;
    cnt       = 0;
    exp_trunc = 1'b0;
    exp_wr    = 1'b0;
  endtask

  task automatic knobs_off();
    full_at = -1; full_left = 0; stall_req = -1; stall_at = -1; stall_left = 0;
    full_pct = 0; stall_pct = 0;
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, advance model at posedge
  task automatic step();
    logic [NREQ-1:0] exp_grant, exp_ready;
    logic [DSIZE:0]  head;
    logic            v;
    int              w;
    @(negedge clk);
    fifo_full = 1'b0;
    if (owner >= 0 && cnt == full_at && full_left > 0) begin
      fifo_full = 1'b1;
      full_left--;
    end else if (int'($urandom_range(0, 99)) < full_pct) begin
      fifo_full = 1'b1;
    end
    for (int r = 0; r < NREQ; r++) begin
      head = (qcount(r) > 0) ? qmem[r][qhd[r] % QD] : '0;
      v    = (qcount(r) > 0);
      if (r == owner && v) begin
        if (r == stall_req && cnt == stall_at && stall_left > 0) begin
          v = 1'b0;
          stall_left--;
        end else if (int'($urandom_range(0, 99)) < stall_pct) begin
          v = 1'b0;
        end
      end
      valid[r]                 = v;
      last[r]                  = head[DSIZE];
      data[r*DSIZE +: DSIZE]   = head[DSIZE-1:0];
    end
    #1;
    exp_grant = '0;
    exp_ready = '0;
    exp_wr    = 1'b0;
    if (owner >= 0) begin
      exp_grant[owner] = 1'b1;
      exp_ready[owner] = ~fifo_full;
      exp_wr           = valid[owner] & ~fifo_full;
    end
    check_eq("grant", 32'(grant), 32'(exp_grant));
    check_eq("busy",  32'(busy),  32'(owner >= 0));
    check_eq("trunc", 32'(trunc), 32'(exp_trunc));
    check_eq("ready", 32'(ready), 32'(exp_ready));
    check_eq("wr_en", 32'(wr_en), 32'(exp_wr));
    if (exp_wr) begin
      head = qmem[owner][qhd[owner] % QD];
      check_eq("wr_data", 32'(wr_data), 32'(head[DSIZE-1:0]));
    end
    @(posedge clk);
    exp_trunc = 1'b0;
    if (owner < 0) begin
      if (valid != '0) begin
        w = -1;
        for (int i = 0; i < NREQ; i++)
          if (w < 0 && valid[(rr + i) % NREQ]) w = (rr + i) % NREQ;
        owner = w;
        cnt   = 0;
      end
    end else if (exp_wr) begin
      head = qmem[owner][qhd[owner] % QD];
      qhd[owner]++;
      cnt++;
      if (head[DSIZE] || cnt == MAXBEATS) begin
        exp_trunc = ~head[DSIZE];
        rr        = (owner + 1) % NREQ;
        owner     = -1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached;
    for (int r = 0; r < NREQ; r++) begin qhd[r] = 0; qtl[r] = 0; end
    model_reset();
    knobs_off();
    wr_rst    = 1'b0;
    valid     = '0;
    data      = '0;
    last      = '0;
    fifo_full = 1'b0;
    #1;
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_busy",  32'(busy),  32'h0);
    check_eq("rst_trunc", 32'(trunc), 32'h0);
    check_eq("rst_wr_en", 32'(wr_en), 32'h0);
    #20 wr_rst = 1'b1;

    // Single requester, three beats
    push_beat(0, 8'h11, 1'b0);
    push_beat(0, 8'h22, 1'b0);
    push_beat(0, 8'h33, 1'b1);
    run(8);

    // Round-robin with one-beat packets from everyone
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < NREQ; r++) push_pkt(r, 1, 8'h40 + 16*r + k);
    run(20);

    // FIFO full for five cycles mid-packet
    full_at = 3; full_left = 5;
    push_pkt(1, 8, 8'h80);
    run(20);
    knobs_off();

    // Truncation at MAXBEATS, remainder re-arbitrated
    push_pkt(2, 20, 8'hA0);
    run(32);

    // Async reset after two of five beats
    push_pkt(0, 5, 8'hC0);
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      step();
      if (owner == 0 && cnt == 2) reached = 1'b1;
    end
    check_eq("rst_reach", 32'(reached), 32'h1);
    #2 wr_rst = 1'b0;
    #1;
    check_eq("arst_grant", 32'(grant), 32'h0);
    check_eq("arst_busy",  32'(busy),  32'h0);
    check_eq("arst_wr_en", 32'(wr_en), 32'h0);
    check_eq("arst_ready", 32'(ready), 32'h0);
    valid = '0;
    for (int r = 0; r < NREQ; r++) qhd[r] = qtl[r];
    model_reset();
    @(negedge clk);
    @(negedge clk);
    wr_rst = 1'b1;
    push_pkt(3, 1, 8'hD3);
    push_pkt(1, 1, 8'hD1);
    run(10);

    // Grantee stall while another requester waits
    stall_req = 1; stall_at = 2; stall_left = 3;
    push_pkt(1, 6, 8'hE0);
    push_pkt(3, 3, 8'hF0);
    run(25);
    knobs_off();

    // Randomized traffic with FIFO-full and grantee stalls
    full_pct = 15; stall_pct = 15;
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < NREQ; r++)
        if (qcount(r) == 0 && $urandom_range(0, 9) == 0)
          push_pkt(r, int'($urandom_range(1, 24)), int'($urandom_range(0, 255)));
      step();
    end
    knobs_off();
    run(300);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
